// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter family.
// Combinational helpers only, no latency.
// No flow control; pure definitions.
package counter_pkg;

  // Count direction as seen by the toggle-enable logic.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } cnt_dir_t;

  // A load value above the terminal value is pinned to the terminal value,
  // so the counter can never leave its 0..MAX range.
  function automatic logic [31:0] clamp_load(input logic [31:0] din,
                                             input logic [31:0] max);
    return (din > max) ? max : din;
  endfunction

endpackage

// File: rtl/tff_bit.sv
// Single T flip-flop cell: q toggles on a rising clk edge when t is high.
// Latency: one clock from t to q; qb is the complement of q.
// No backpressure; synchronous active-low reset drives q=0, qb=1.
module tff_bit (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  // Toggle storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX+1) counter built from T flip-flop cells, with load and terminal count.
// Latency: q/qb/wrap/sat one clock after the en/up/load sample; tc is combinational.
// No backpressure; priority rst > load > en > hold. Macro UPDOWN_COUNTER_SAT_EN selects saturation.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                               : ((32'd1 << WIDTH) - 32'd1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

  cnt_dir_t         dir;
  logic             at_max;
  logic             at_zero;
  logic             term_step;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] and_up;
  logic [WIDTH-1:0] and_dn;
  logic [WIDTH-1:0] t_vec;
  logic             wrap_set;

  assign dir     = up ? DIR_UP : DIR_DOWN;
  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);
  assign tc      = en & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_zero));

  // A count step that lands on a terminal condition (wraps or saturates).
  assign term_step = ~load & tc;

  // Target value for the irregular cases (load, wrap, saturation hold).
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = WIDTH'(clamp_load(32'(din), 32'(MAX)));
    end else if (en) begin
      if (dir == DIR_UP) begin
        nxt = at_max ? '0 : q + WIDTH'(1);
      end else begin
        nxt = at_zero ? MAX_Q : q - WIDTH'(1);
      end
`ifdef UPDOWN_COUNTER_SAT_EN
      if (tc) begin
        nxt = q;
      end
`endif
    end
  end

  // Carry/borrow chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    and_up    = '0;
    and_dn    = '0;
    and_up[0] = 1'b1;
    and_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      and_up[i] = and_up[i-1] & q[i-1];
      and_dn[i] = and_dn[i-1] & ~q[i-1];
    end
  end

  // Per-bit toggle enables: chains for ordinary steps, q^nxt for load/wrap/hold.
  always_comb begin
    t_vec = '0;
    if (load || term_step) begin
      t_vec = q ^ nxt;
    end else if (en) begin
      t_vec = (dir == DIR_UP) ? and_up : and_dn;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_bit u_tff (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

`ifdef UPDOWN_COUNTER_SAT_EN
  assign wrap_set = 1'b0;

  // Sticky saturation flag: set on a held terminal step, cleared by load or reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat <= 1'b0;
    end else if (load) begin
      sat <= 1'b0;
    end else if (term_step) begin
      sat <= 1'b1;
    end
  end
`else
  assign wrap_set = term_step;
  assign sat      = 1'b0;
`endif

  // Wrap pulse: high for the one cycle following an edge where the count wrapped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_set;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: MAX=15, MAX=9 and 1-bit instances plus a two-stage cascade.
// An arithmetic model is compared every cycle; directed literals pin the model.
// Build with UPDOWN_COUNTER_SAT_EN defined to exercise saturating mode.
`timescale 1ns/1ps
module tb_updown_mod_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, casc_en;
  logic [3:0] din;
  logic [0:0] w_din;
  assign w_din = din[0:0];

  logic [3:0] a_q, a_qb, b_q, b_qb, lo_q, lo_qb, hi_q, hi_qb;
  logic [0:0] w_q, w_qb;
  logic a_tc, a_wrap, a_sat, b_tc, b_wrap, b_sat, w_tc, w_wrap, w_sat;
  logic lo_tc, lo_wrap, lo_sat, hi_tc, hi_wrap, hi_sat;

  updown_mod_counter #(.WIDTH(4), .MAX(15)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(a_q), .qb(a_qb), .tc(a_tc), .wrap(a_wrap), .sat(a_sat));
  updown_mod_counter #(.WIDTH(4), .MAX(9)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(b_q), .qb(b_qb), .tc(b_tc), .wrap(b_wrap), .sat(b_sat));
  updown_mod_counter #(.WIDTH(1), .MAX(1)) u_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(w_din),
    .q(w_q), .qb(w_qb), .tc(w_tc), .wrap(w_wrap), .sat(w_sat));
  updown_mod_counter #(.WIDTH(4), .MAX(15)) u_lo (
    .clk(clk), .rst(rst), .en(casc_en), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(lo_q), .qb(lo_qb), .tc(lo_tc), .wrap(lo_wrap), .sat(lo_sat));
  updown_mod_counter #(.WIDTH(4), .MAX(15)) u_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(hi_q), .qb(hi_qb), .tc(hi_tc), .wrap(hi_wrap), .sat(hi_sat));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: index 0 = MAX 15, 1 = MAX 9, 2 = 1-bit MAX 1.
  int  maxv [3] = '{15, 9, 1};
  int  mask [3] = '{15, 15, 1};
  int  mq [3];
  int  mw [3];
  int  ms [3];
  int  cc, cwrap, d;
  bit  mvalid = 1'b0;
  int  a_pulses = 0;
  int  hi_pulses = 0;

  task automatic step_model(input int mx, inout int q, inout int w, inout int s,
                            input logic r, input logic ld, input logic e,
                            input logic u, input int dv);
    bit term;
    if (!r) begin
      q = 0; w = 0; s = 0;
    end else if (ld) begin
      q = (dv > mx) ? mx : dv; w = 0; s = 0;
    end else if (e) begin
      term = u ? (q == mx) : (q == 0);
      w = 0;
      if (term && SAT) s = 1;
      else if (term) begin q = u ? 0 : mx; w = 1; end
      else q = u ? q + 1 : q - 1;
    end else begin
      w = 0;
    end
  endtask

  // Advance the model on each rising edge using the inputs held across it.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      d = (k == 2) ? int'(din[0]) : int'(din);
      step_model(maxv[k], mq[k], mw[k], ms[k], rst, load, en, up, d);
    end
    if (!rst) begin
      cc = 0; cwrap = 0; mvalid = 1'b1;
    end else if (casc_en) begin
      cwrap = (cc == 255) ? 1 : 0;
      cc = (cc + 1) % 256;
    end else begin
      cwrap = 0;
    end
  end

  task automatic check_inst(input string nm, input int k, input int q, input int qb,
                            input int tc, input int wr, input int st);
    int etc;
    etc = (en && (up ? (mq[k] == maxv[k]) : (mq[k] == 0))) ? 1 : 0;
    check({nm, "_q"},    q,  mq[k]);
    check({nm, "_qb"},   qb, ~mq[k] & mask[k]);
    check({nm, "_tc"},   tc, etc);
    check({nm, "_wrap"}, wr, mw[k]);
    check({nm, "_sat"},  st, ms[k]);
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      check_inst("a", 0, a_q, a_qb, a_tc, a_wrap, a_sat);
      check_inst("b", 1, b_q, b_qb, b_tc, b_wrap, b_sat);
      check_inst("w", 2, w_q, w_qb, w_tc, w_wrap, w_sat);
`ifndef UPDOWN_COUNTER_SAT_EN
      check("casc_q", {hi_q, lo_q}, cc);
      check("casc_hi_wrap", hi_wrap, cwrap);
`endif
      if (a_wrap) a_pulses++;
      if (hi_wrap) hi_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0; casc_en = 1'b0;
    cyc(2);
    check("rst_a_q", a_q, 0);
    check("rst_a_qb", a_qb, 15);
    check("rst_a_wrap", a_wrap, 0);
    check("rst_a_sat", a_sat, 0);

    // Count up 17 steps from reset.
    rst = 1'b1; en = 1'b1; up = 1'b1; a_pulses = 0;
    cyc(17);
    check("up17_a_q", a_q, SAT ? 15 : 1);
    check("up17_b_q", b_q, SAT ? 9 : 7);
    check("up17_w_q", w_q, 1);
    check("up17_a_pulses", a_pulses, SAT ? 0 : 1);

    // Down count of the MAX=9 instance from 0.
    rst = 1'b0;
    cyc(1);
    check("dn_b_rst", b_q, 0);
    rst = 1'b1; up = 1'b0;
    cyc(1);
    check("dn1_b_q", b_q, SAT ? 0 : 9);
    check("dn1_a_q", a_q, SAT ? 0 : 15);
    cyc(10);
    check("dn11_b_q", b_q, SAT ? 0 : 9);
    check("dn11_a_q", a_q, SAT ? 0 : 5);

    // Load beats count; over-range load clamps to MAX.
    load = 1'b1; en = 1'b1; din = 4'd12; up = 1'b1;
    cyc(1);
    check("ld_b_q", b_q, 9);
    check("ld_b_wrap", b_wrap, 0);
    check("ld_a_q", a_q, 12);
    check("ld_w_q", w_q, 0);
    load = 1'b0;
    cyc(1);
    check("ld_next_b_q", b_q, SAT ? 9 : 0);
    check("ld_next_b_wrap", b_wrap, SAT ? 0 : 1);
    check("ld_next_b_sat", b_sat, SAT ? 1 : 0);
    check("ld_next_a_q", a_q, 13);

    // Reset mid-count overrides load and en.
    load = 1'b1; din = 4'd6;
    cyc(1);
    load = 1'b0;
    cyc(1);
    check("mid_a_q7", a_q, 7);
    rst = 1'b0; load = 1'b1; din = 4'd3; en = 1'b1;
    cyc(1);
    check("mid_rst_a_q", a_q, 0);
    check("mid_rst_a_qb", a_qb, 15);
    check("mid_rst_a_sat", a_sat, 0);
    rst = 1'b1; load = 1'b0;
    cyc(1);
    check("mid_resume_a_q", a_q, 1);

    // Hold.
    en = 1'b0;
    cyc(3);
    check("hold_a_q", a_q, 1);
    check("hold_a_wrap", a_wrap, 0);

    // Approach the top from 14.
    load = 1'b1; din = 4'd14; en = 1'b1; up = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    check("top_a_q15", a_q, 15);
    cyc(1);
    check("top_a_q2", a_q, SAT ? 15 : 0);
    check("top_a_sat", a_sat, SAT ? 1 : 0);
    check("top_a_wrap", a_wrap, SAT ? 0 : 1);
    cyc(1);
    check("top_a_q3", a_q, SAT ? 15 : 1);
    load = 1'b1; din = 4'd0;
    cyc(1);
    check("top_ld_a_q", a_q, 0);
    check("top_ld_a_sat", a_sat, 0);
    load = 1'b0; en = 1'b0;

`ifndef UPDOWN_COUNTER_SAT_EN
    // Two-stage cascade through 256 steps.
    rst = 1'b0;
    cyc(1);
    rst = 1'b1; casc_en = 1'b1; hi_pulses = 0;
    cyc(256);
    casc_en = 1'b0;
    @(negedge clk);
    #1;
    check("casc_final", {hi_q, lo_q}, 0);
    check("casc_hi_pulses", hi_pulses, 1);
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo counter built from per-bit T flip-flop cells with computed toggle enables. All bits switch on the same clock edge, so there is no ripple skew. Adds direction control, parallel load, a programmable terminal value and a terminal-count output for cascading. It is the general-purpose counter for timers, dividers and address generators in this codebase.

## Interface
Parameters:
- WIDTH, 4: counter width in bits, 1..32.
- MAX, 2**WIDTH-1: terminal value, 1..2**WIDTH-1. The count range is 0..MAX, so the modulus is MAX+1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  count enable; one step per clock while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- din  in  WIDTH  load value.
- q  out  WIDTH  current count.
- qb  out  WIDTH  bitwise complement of q, always equal to ~q.
- tc  out  1  terminal count, combinational: en & ((up & q==MAX) | (~up & q==0)).
- wrap  out  1  registered one-cycle pulse; high in the cycle after q wrapped.
- sat  out  1  sticky saturation flag (see Configuration).

## Operation
- Priority on each rising clk edge: rst==0 > load > en > hold.
- Reset (rst==0): q=0, qb=all ones, wrap=0, sat=0. tc therefore reflects q==0 with the current en/up.
- Load (load==1): q takes din. If din > MAX, q takes MAX. wrap clears to 0; sat clears to 0. en is ignored that cycle.
- Count (en==1, load==0):
  - Up: q+1. If q==MAX, q goes to 0.
  - Down: q-1. If q==0, q goes to MAX.
  - Non-power-of-two MAX must wrap exactly at MAX, never at 2**WIDTH-1.
- Hold (en==0): q, qb and sat unchanged; wrap drops to 0.
- Toggle rule per bit i:
  - Up, no wrap: T_i = AND of q[i-1:0].
  - Down, no wrap: T_i = AND of ~q[i-1:0].
  - On wrap or load, T_i = q[i] XOR next[i].
- wrap is set to 1 exactly on an edge where a count wrapped. On every other edge it is 0.
- Direction change mid-count takes effect on the next edge; no extra state is kept.

## Timing
- q, qb, wrap and sat are registered; q updates one clock after the en, up or load sample.
- tc is combinational from q, en and up, valid in the same cycle. Cascading: connect tc to the next stage's en; both stages step on the same edge.
- Reset asserted mid-count overrides load and en in that cycle. The first count after release happens on the first edge with rst==1 and en==1.
- Simultaneous load and en: load wins, no count step is taken.
- WIDTH==1 with MAX==1 behaves as a single T flip-flop with toggle = en.

## Configuration
- Macro `UPDOWN_COUNTER_SAT_EN`.
- Defined: saturating mode. At a terminal condition (tc==1) q holds at MAX (up) or 0 (down) instead of wrapping. wrap stays 0. sat sets to 1 and stays set until load or reset.
- Undefined: wrapping mode as described in Operation. sat is tied to 0.

## Structure
- Shared package `counter_pkg` holds:
  - typedef `cnt_dir_t` (DIR_DOWN=0, DIR_UP=1);
  - helper function `clamp_load(din, MAX)`.
- Sub-module `tff_bit` is a single T flip-flop cell: ports clk, rst (sync, active-low), t, q, qb; reset q=0, qb=1. It is instantiated WIDTH times by a generate loop.
- The top level computes the per-bit T vector, wrap/clamp/saturation logic and the wrap/sat registers.

## Test plan
- Reset then count: WIDTH=4, MAX=15, up=1, en=1 for 17 clocks. Expect q=0,1,…,15,0,1. wrap=1 only in the cycle after 15→0. tc=1 while q==15.
- Modulo and down: MAX=9, up=0, en=1 from q=0. Expect q=9,8,…,0,9. tc=1 only at q==0.
- Load priority and clamp: load=1 with en=1 and din=12, MAX=9. Expect q=9, no count step, wrap=0. Next edge with en=1, up=1 gives q=0 and wrap=1.
- Reset mid-operation: q=7 while counting; drive rst=0 together with load=1 and din=3. Expect q=0, qb=4'hF, sat=0. Count resumes from 0.
- Cascade: two WIDTH=4 instances, upper en = lower tc. After 256 enabled clocks from reset, expect {upper,lower}=8'h00, with exactly one upper wrap pulse.
- Saturation with `UPDOWN_COUNTER_SAT_EN`: MAX=15, up=1, counting from 14. Expect q=15,15,15 and sat=1 from the edge after 15 is reached. Then load=1, din=0 gives q=0, sat=0.
